// File: rtl/sysarr_add_arbiter.sv
// sysarr_add_arbiter: round-robin sequencer sharing one pipelined FP16 adder
// among NUM_REQ accumulators. One operation in flight; operands and results
// pass through untouched.
// Optional watchdog: define SYSARR_ADD_ARB_TIMEOUT_EN to recover from a hung
// adder (result forced to FP16 qNaN, sticky timeout_err).
module sysarr_add_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                    clk,
  input  logic                    RST,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [16*NUM_REQ-1:0]   req_op1,
  input  logic [16*NUM_REQ-1:0]   req_op2,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [15:0]             rsp_data,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic                    add_start,
  output logic [15:0]             add_input1,
  output logic [15:0]             add_input2,
  input  logic                    add_value_ready,
  input  logic [15:0]             add_output,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   last_grant_q, owner_q, winner;
  logic            win_found, accept, wd_fire;
  logic [15:0]     op1_q, op2_q, result_q;
  logic [15:0]     op1_a [NUM_REQ];
  logic [15:0]     op2_a [NUM_REQ];

  // Split the flat operand buses into per-requester words
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign op1_a[i] = req_op1[16*i +: 16];
    assign op2_a[i] = req_op2[16*i +: 16];
  end

  // Round-robin search starting just above the last served requester
  always_comb begin
    winner    = '0;
    win_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!win_found && req_valid[(int'(last_grant_q) + k) % NUM_REQ]) begin
        win_found = 1'b1;
        winner    = IW'((int'(last_grant_q) + k) % NUM_REQ);
      end
    end
  end

  assign accept = (state_q == IDLE) && win_found;

  // Accept strobe is combinational so the requester sees it in the grant cycle
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[winner] = 1'b1;
  end

  // Result strobe decoded from the state register and the latched owner
  always_comb begin
    rsp_valid = '0;
    if (state_q == RESP) rsp_valid[owner_q] = 1'b1;
  end

  // Next-state logic; the adder handshake is only looked at while waiting
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (add_value_ready || wd_fire) state_d = RESP;
      RESP:    if (rsp_ready[owner_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, operand/owner capture on accept, result capture, rotation pointer
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q      <= IDLE;
      last_grant_q <= IW'(NUM_REQ - 1);
      owner_q      <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      result_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op1_q   <= op1_a[winner];
        op2_q   <= op2_a[winner];
        owner_q <= winner;
      end
      if (state_q == WAIT) begin
        if (add_value_ready) result_q <= add_output;
        else if (wd_fire)    result_q <= 16'h7E00;
      end
      if (state_q == RESP && rsp_ready[owner_q]) last_grant_q <= owner_q;
    end
  end

`ifdef SYSARR_ADD_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wait_cnt_q;
  logic          timeout_q;

  // Fires on the last allowed WAIT cycle so RESP follows TIMEOUT_CYCLES WAIT cycles
  assign wd_fire = (state_q == WAIT) && !add_value_ready &&
                   (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // WAIT-cycle counter cleared on issue; sticky error flag until reset
  always_ff @(posedge clk) begin
    if (RST) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      if (state_q == ISSUE)
        wait_cnt_q <= '0;
      else if (state_q == WAIT && !add_value_ready)
        wait_cnt_q <= wait_cnt_q + 1'b1;
      if (wd_fire) timeout_q <= 1'b1;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign wd_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign add_start  = (state_q == ISSUE);
  assign add_input1 = op1_q;
  assign add_input2 = op2_q;
  assign rsp_data   = result_q;
  assign busy       = (state_q != IDLE);

endmodule
